ads131_frame_unpacker: RTL
==========================

Name: ads131_frame_unpacker

Overview:
- Sits directly downstream of the ADS131A0x SPI master and consumes its received 32-bit MISO words.
- Splits each data-read frame (one status word, then NUM_CH channel words) into the 16-bit status response and per-channel 24-bit samples.
- Samples are sign-extended to 32 bits, tagged with their channel index, and buffered in a FIFO.
- Output is a valid/ready stream for the downstream sample consumer (filter/packetiser).

Parameters:
- NUM_CH, 4, channels per frame (1..8).
- FIFO_DEPTH, 16, sample FIFO entries; power of 2, 4..256.
- LEVEL_W, 9, width of fifo_level; must be able to hold FIFO_DEPTH.

Ports:
- system_clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse from the SPI master at CS assertion of a data-read frame.
- word_valid  in  1  one-cycle pulse; word_data holds a complete received 32-bit word.
- word_data  in  32  received word, MSB first; 24-bit ADC data occupies [31:8].
- sample_valid  out  1  FIFO head entry valid.
- sample_ready  in  1  consumer accepts the head entry.
- sample_data  out  32  sign-extended sample.
- sample_ch  out  3  channel index, 0..NUM_CH-1.
- sample_last  out  1  high on the channel NUM_CH-1 entry.
- status_word  out  16  last captured status response (word_data[31:16]).
- status_valid  out  1  one-cycle pulse when status_word updates.
- frame_error  out  1  sticky framing-error flag; cleared only by reset.
- overflow_count  out  16  samples dropped because the FIFO was full; saturating.
- fifo_level  out  LEVEL_W  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE, FIFO emptied, all outputs 0 (sample_valid=0, sample_data=0, sample_ch=0, sample_last=0, status_word=0, status_valid=0, frame_error=0, overflow_count=0, fifo_level=0).
- Reset mid-frame or with FIFO contents: everything is discarded; outputs are 0 in the cycle after reset is sampled.
- FSM states:
  - IDLE: on frame_start, go to STATUS.
  - STATUS: on word_valid, capture status_word=word_data[31:16], pulse status_valid next cycle, set ch=0, go to CHANNEL.
  - CHANNEL: on word_valid, push {ch==NUM_CH-1, ch, {{8{word_data[31]}}, word_data[31:8]}}. If ch==NUM_CH-1, go to IDLE; otherwise ch increments.
- Stray word: word_valid in IDLE sets frame_error; the word is discarded.
- frame_start while in STATUS or CHANNEL (short frame): sets frame_error and restarts at STATUS. Samples already pushed stay in the FIFO.
- frame_start and word_valid in the same cycle: the word is taken as the status word of the new frame (FSM goes to CHANNEL).
- FIFO behaviour:
  - First-word-fall-through, registered.
  - A push in cycle N is visible on sample_valid in cycle N+1 if the FIFO was empty.
  - Pop occurs when sample_valid && sample_ready.
  - Outputs are stable while sample_valid=1 and sample_ready=0.
- FIFO full:
  - A push with no pop in the same cycle is dropped; overflow_count increments, saturating at 0xFFFF.
  - A push and pop in the same cycle while full are both accepted; level is unchanged.
  - The FSM keeps advancing regardless of drops.
- Empty: sample_valid=0; sample_ready is ignored.
- fifo_level is pushes minus pops; it never exceeds FIFO_DEPTH.

Optional Feature:
- Macro: ADS131_FRAME_TIMESTAMP_EN.
- Defined:
  - Adds output port sample_timestamp (32 bits).
  - A free-running 32-bit system_clock counter runs from 0 at reset and wraps at 2^32.
  - The counter is latched on frame_start and stored in every FIFO entry of that frame.
  - sample_timestamp is 0 after reset.
- Undefined: no port, no counter, FIFO width unchanged from the base design.

Test Plan:
1. Normal frame: reset; sample_ready=1; frame_start; words 0x2220_0000, 0x7FFF_FF00, 0x8000_0000, 0x0000_0100, 0xFFFF_FF00 -> status_word=0x2220 with one status_valid pulse; samples 0x007FFFFF ch0, 0xFF800000 ch1, 0x00000001 ch2, 0xFFFFFFFF ch3 with sample_last=1; frame_error=0.
2. Overflow: sample_ready=0; 5 frames (20 samples) -> fifo_level=16, overflow_count=4. Then sample_ready=1 -> first 16 samples delivered in order, ch sequence 0,1,2,3 repeating.
3. Short frame: frame_start, status word, 2 channel words, frame_start, full frame -> frame_error=1; partial ch0, ch1 delivered; new frame yields ch0..ch3 with last on ch3.
4. Stray/simultaneous: word_valid in IDLE -> frame_error=1, no sample. Then frame_start together with word_valid 0x2230_0000 -> status_word=0x2230.
5. Full push+pop: fill to 16, then push in the same cycle as a pop -> fifo_level stays 16, overflow_count unchanged, new sample at tail.
6. Reset mid-frame: assert reset after 2 channel words with 3 entries queued -> next cycle all outputs 0. Subsequent full frame parses from ch0.

Source files
------------

// File: rtl/ads131_frame_unpacker_if.sv
// ads131_frame_unpacker_if
// Sample stream between the frame unpacker and its downstream consumer.
//   sample_valid     head entry valid (producer -> consumer)
//   sample_ready     consumer accepts the head entry (consumer -> producer)
//   sample_data      sign-extended 24-bit sample
//   sample_ch        channel index of the entry
//   sample_last      entry belongs to the last channel of a frame
//   sample_timestamp frame timestamp, only with ADS131_FRAME_TIMESTAMP_EN defined
interface ads131_frame_unpacker_if;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] sample_data;
    logic [2:0]  sample_ch;
    logic        sample_last;
`ifdef ADS131_FRAME_TIMESTAMP_EN
    logic [31:0] sample_timestamp;
`endif

    modport master (
        input  sample_ready,
        output sample_valid, sample_data, sample_ch, sample_last
`ifdef ADS131_FRAME_TIMESTAMP_EN
        , output sample_timestamp
`endif
    );

    modport slave (
        output sample_ready,
        input  sample_valid, sample_data, sample_ch, sample_last
`ifdef ADS131_FRAME_TIMESTAMP_EN
        , input sample_timestamp
`endif
    );
endinterface

// File: rtl/ads131_frame_unpacker.sv
// ads131_frame_unpacker
// Splits ADS131A0x data-read frames (status word + NUM_CH channel words) received from the
// SPI master into a status response and sign-extended, channel-tagged samples held in a
// first-word-fall-through FIFO.
// Ports:
//   system_clock, reset   clock and synchronous active-high reset
//   frame_start           pulse at CS assertion of a data-read frame
//   word_valid, word_data received 32-bit MISO word (ADC data in [31:8])
//   smp                   sample stream (master side of ads131_frame_unpacker_if)
//   status_word/_valid    last status response and its one-cycle update pulse
//   frame_error           sticky framing error (stray word or short frame)
//   overflow_count        saturating count of samples dropped on a full FIFO
//   fifo_level            current FIFO occupancy
// Optional feature: define ADS131_FRAME_TIMESTAMP_EN to tag each entry with the value of a
// free-running cycle counter latched at frame_start (smp.sample_timestamp).
module ads131_frame_unpacker #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEVEL_W    = 9
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic                     word_valid,
    input  logic [31:0]              word_data,
    ads131_frame_unpacker_if.master  smp,
    output logic [15:0]              status_word,
    output logic                     status_valid,
    output logic                     frame_error,
    output logic [15:0]              overflow_count,
    output logic [LEVEL_W-1:0]       fifo_level
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
`ifdef ADS131_FRAME_TIMESTAMP_EN
    localparam int unsigned EntryW = 68;
`else
    localparam int unsigned EntryW = 36;
`endif

    typedef enum logic [1:0] {StIdle, StStatus, StChannel} state_e;

    state_e              state_q, state_d;
    logic [2:0]          ch_q, ch_d;
    logic                push, capture, set_err, last_ch;
    logic [EntryW-1:0]   push_entry;
    logic [31:0]         sample_sext;

    logic [EntryW-1:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     rd_q, wr_q;
    logic [LEVEL_W-1:0]  count_q;
    logic [15:0]         ovf_q;
    logic [15:0]         status_word_q;
    logic                status_valid_q, frame_error_q;
    logic                empty, full, pop, wr_en, drop;
    logic [EntryW-1:0]   head;

    // Low byte of each word carries no ADC data.
    logic unused_word_low;
    assign unused_word_low = ^word_data[7:0];

    assign last_ch     = (ch_q == 3'(NUM_CH - 1));
    assign sample_sext = {{8{word_data[31]}}, word_data[31:8]};

`ifdef ADS131_FRAME_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, frame_ts_q;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            ts_cnt_q   <= '0;
            frame_ts_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (frame_start) frame_ts_q <= ts_cnt_q;
        end
    end

    assign push_entry = {frame_ts_q, last_ch, ch_q, sample_sext};
`else
    assign push_entry = {last_ch, ch_q, sample_sext};
`endif

    // Frame parser. frame_start always wins: it restarts the frame, and a word arriving in the
    // same cycle is the new frame's status word.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        push    = 1'b0;
        capture = 1'b0;
        set_err = 1'b0;
        if (frame_start) begin
            set_err = (state_q != StIdle);
            if (word_valid) begin
                capture = 1'b1;
                ch_d    = '0;
                state_d = StChannel;
            end else begin
                state_d = StStatus;
            end
        end else if (word_valid) begin
            unique case (state_q)
                StIdle:   set_err = 1'b1;
                StStatus: begin
                    capture = 1'b1;
                    ch_d    = '0;
                    state_d = StChannel;
                end
                StChannel: begin
                    push = 1'b1;
                    if (last_ch) state_d = StIdle;
                    else         ch_d    = ch_q + 3'd1;
                end
                default:  state_d = StIdle;
            endcase
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == LEVEL_W'(FIFO_DEPTH));
    assign pop   = !empty && smp.sample_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q        <= StIdle;
            ch_q           <= '0;
            rd_q           <= '0;
            wr_q           <= '0;
            count_q        <= '0;
            ovf_q          <= '0;
            status_word_q  <= '0;
            status_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            status_valid_q <= capture;
            if (capture) status_word_q <= word_data[31:16];
            if (set_err) frame_error_q <= 1'b1;
            if (wr_en)   wr_q <= wr_q + PtrW'(1);
            if (pop)     rd_q <= rd_q + PtrW'(1);
            if (wr_en && !pop)      count_q <= count_q + LEVEL_W'(1);
            else if (!wr_en && pop) count_q <= count_q - LEVEL_W'(1);
            if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
        end
    end

    // Storage needs no reset: outputs are gated by the occupancy count.
    always_ff @(posedge system_clock) begin
        if (wr_en) mem_q[wr_q] <= push_entry;
    end

    assign head = mem_q[rd_q];

    always_comb begin
        smp.sample_valid = !empty;
        smp.sample_data  = empty ? 32'd0 : head[31:0];
        smp.sample_ch    = empty ? 3'd0  : head[34:32];
        smp.sample_last  = empty ? 1'b0  : head[35];
`ifdef ADS131_FRAME_TIMESTAMP_EN
        smp.sample_timestamp = empty ? 32'd0 : head[67:36];
`endif
    end

    assign status_word    = status_word_q;
    assign status_valid   = status_valid_q;
    assign frame_error    = frame_error_q;
    assign overflow_count = ovf_q;
    assign fifo_level     = count_q;

endmodule
